// File: rtl/line_sched_ctrl.sv
// rtl/line_sched_ctrl.sv - line scheduler for the HLS pixel kernel; optional watchdog via LINE_SCHED_WDT_EN
module line_sched_ctrl #(
  parameter int PW             = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ENABLE,
  input  logic [PW-1:0] CFG_WIDTH,
  input  logic [PW-1:0] CFG_HEIGHT,
  input  logic          CLR_ERR,
  input  logic          READ_LINE_DONE,
  input  logic [PW-1:0] READ_POSY,
  output logic          LINE_READY,
  output logic          KICK,
  output logic [PW-1:0] POSX,
  output logic [PW-1:0] POSY,
  input  logic          IN_DE,
  input  logic          OUT_DE,
  output logic          WRITE_LINE_DONE,
  output logic [PW-1:0] WRITE_POSY,
  output logic          FRAME_DONE,
  output logic          BUSY,
  output logic          OVERRUN,
  output logic          PROTO_ERR,
  output logic          TIMEOUT
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic          pend_v;
  logic [PW-1:0] pend_y;
  logic          kick;
  logic [PW-1:0] posx;
  logic [PW-1:0] posy;
  logic [PW-1:0] wposx;
  logic [PW-1:0] width_r;
  logic [PW-1:0] height_r;
  logic          wld;
  logic [PW-1:0] wposy;
  logic          frame_done;
  logic          overrun;
  logic          proto_err;
  logic          timeout;

  logic          launch_req;
  logic [PW-1:0] launch_y;
  logic          rld_direct;
  logic          rld_store;
  logic          rld_drop;
  logic          zw_err;
  logic          in_ok;
  logic          in_err;
  logic          out_ok;
  logic          out_err;
  logic          line_last_in;
  logic          line_complete;
  logic          to_set;
  logic [PW-1:0] width_m1;
  logic [PW-1:0] height_m1;

  assign width_m1   = width_r - PW'(1);
  assign height_m1  = height_r - PW'(1);

  // The pending slot takes priority over a fresh line-done as launch source.
  assign launch_req = (state == IDLE) && ENABLE && (pend_v || READ_LINE_DONE);
  assign launch_y   = pend_v ? pend_y : READ_POSY;

  // A line-done not consumed by a direct launch goes to the slot if it is free
  // (or being vacated by this launch); otherwise it is lost.
  assign rld_direct = launch_req && !pend_v;
  assign rld_store  = READ_LINE_DONE && !rld_direct && (!pend_v || launch_req);
  assign rld_drop   = READ_LINE_DONE && !rld_direct && pend_v && !launch_req;

  assign zw_err     = launch_req && (CFG_WIDTH == '0);

  assign in_ok      = IN_DE && kick;
  assign in_err     = IN_DE && !kick;
  assign out_ok     = OUT_DE && (state != IDLE) && (wposx != width_r);
  assign out_err    = OUT_DE && !out_ok;

  assign line_last_in  = in_ok && (posx == width_m1);
  assign line_complete = (state == DRAIN) &&
                         ((out_ok && (wposx == width_m1)) || (wposx == width_r));

`ifdef LINE_SCHED_WDT_EN
  logic [31:0] wdt_cnt;

  assign to_set = (state != IDLE) && !IN_DE && !OUT_DE &&
                  (wdt_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Idle-cycle watchdog: restarts on any kernel strobe while a line is active.
  always_ff @(posedge CLK) begin
    if (!RST_N || (state == IDLE) || IN_DE || OUT_DE || to_set) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 32'd1;
    end
  end
`else
  logic unused_wdt;

  assign unused_wdt = ^(32'(TIMEOUT_CYCLES));
  assign to_set     = 1'b0;
`endif

  // Line FSM, pending slot, counters and sticky error flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      pend_v     <= 1'b0;
      pend_y     <= '0;
      kick       <= 1'b0;
      posx       <= '0;
      posy       <= '0;
      wposx      <= '0;
      width_r    <= '0;
      height_r   <= '0;
      wld        <= 1'b0;
      wposy      <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      proto_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      wld        <= 1'b0;
      frame_done <= 1'b0;

      if (rld_store) begin
        pend_v <= 1'b1;
        pend_y <= READ_POSY;
      end else if (launch_req && pend_v) begin
        pend_v <= 1'b0;
      end

      overrun   <= (overrun   && !CLR_ERR) || rld_drop;
      proto_err <= (proto_err && !CLR_ERR) || in_err || out_err || zw_err;
      timeout   <= (timeout   && !CLR_ERR) || to_set;

      if (out_ok) begin
        wposx <= wposx + PW'(1);
      end

      case (state)
        IDLE: begin
          if (launch_req && !zw_err) begin
            posy     <= launch_y;
            width_r  <= CFG_WIDTH;
            height_r <= CFG_HEIGHT;
            posx     <= '0;
            wposx    <= '0;
            kick     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (in_ok) begin
            posx <= posx + PW'(1);
            if (line_last_in) begin
              kick  <= 1'b0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (line_complete && !to_set) begin
            wld        <= 1'b1;
            wposy      <= posy;
            frame_done <= (posy == height_m1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (to_set) begin
        kick  <= 1'b0;
        state <= IDLE;
      end
    end
  end

  assign LINE_READY      = ENABLE && !pend_v;
  assign KICK            = kick;
  assign POSX            = posx;
  assign POSY            = posy;
  assign WRITE_LINE_DONE = wld;
  assign WRITE_POSY      = wposy;
  assign FRAME_DONE      = frame_done;
  assign BUSY            = (state != IDLE) || pend_v;
  assign OVERRUN         = overrun;
  assign PROTO_ERR       = proto_err;
  assign TIMEOUT         = timeout;

endmodule

// File: tb/tb_line_sched_ctrl.sv
// tb/tb_line_sched_ctrl.sv - directed self-checking bench for line_sched_ctrl
module tb_line_sched_ctrl;
  localparam int PW = 12;
`ifdef LINE_SCHED_WDT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 65535;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          ENABLE = 1'b0;
  logic [PW-1:0] CFG_WIDTH = '0;
  logic [PW-1:0] CFG_HEIGHT = '0;
  logic          CLR_ERR = 1'b0;
  logic          READ_LINE_DONE = 1'b0;
  logic [PW-1:0] READ_POSY = '0;
  logic          IN_DE = 1'b0;
  logic          OUT_DE = 1'b0;
  logic          LINE_READY, KICK, WRITE_LINE_DONE, FRAME_DONE, BUSY, OVERRUN, PROTO_ERR, TIMEOUT;
  logic [PW-1:0] POSX, POSY, WRITE_POSY;

  int n_cmp = 0;
  int n_bad = 0;
  int wld_cnt = 0;
  int fd_cnt = 0;
  int fd_orphan = 0;
  logic [PW-1:0] last_wposy = '0;

  line_sched_ctrl #(.PW(PW), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .CFG_WIDTH(CFG_WIDTH), .CFG_HEIGHT(CFG_HEIGHT),
    .CLR_ERR(CLR_ERR), .READ_LINE_DONE(READ_LINE_DONE), .READ_POSY(READ_POSY),
    .LINE_READY(LINE_READY), .KICK(KICK), .POSX(POSX), .POSY(POSY), .IN_DE(IN_DE), .OUT_DE(OUT_DE),
    .WRITE_LINE_DONE(WRITE_LINE_DONE), .WRITE_POSY(WRITE_POSY), .FRAME_DONE(FRAME_DONE),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .PROTO_ERR(PROTO_ERR), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor: reads the previous cycle's outputs at each rising edge.
  always @(posedge CLK) begin
    if (WRITE_LINE_DONE) begin
      wld_cnt = wld_cnt + 1;
      last_wposy = WRITE_POSY;
      if (FRAME_DONE) fd_cnt = fd_cnt + 1;
    end else if (FRAME_DONE) begin
      fd_orphan = fd_orphan + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_rld(input logic [PW-1:0] y);
    READ_POSY = y; READ_LINE_DONE = 1'b1;
    @(negedge CLK);
    READ_LINE_DONE = 1'b0;
  endtask

  task automatic feed_in(input int n);
    repeat (n) begin IN_DE = 1'b1; @(negedge CLK); end
    IN_DE = 1'b0;
  endtask

  task automatic feed_out(input int n);
    repeat (n) begin OUT_DE = 1'b1; @(negedge CLK); end
    OUT_DE = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; ENABLE = 1'b1; IN_DE = 1'b1;
    tick(2);
    IN_DE = 1'b0;
    n_cmp++; if ({KICK, POSX, POSY, WRITE_LINE_DONE, WRITE_POSY, FRAME_DONE, BUSY, OVERRUN, PROTO_ERR, TIMEOUT} !== '0) begin n_bad++; $display("FAIL reset_outputs: got kick=%0b posx=%0d posy=%0d wld=%0b busy=%0b perr=%0b want all 0", KICK, POSX, POSY, WRITE_LINE_DONE, BUSY, PROTO_ERR); end
    n_cmp++; if (LINE_READY !== 1'b1) begin n_bad++; $display("FAIL reset_line_ready: got %0b want 1", LINE_READY); end
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_full_line;
    int base, fbase;
    CFG_WIDTH = 12'd1600; CFG_HEIGHT = 12'd1200;
    base = wld_cnt; fbase = fd_cnt;
    n_cmp++; if (KICK !== 1'b0) begin n_bad++; $display("FAIL t1_kick_idle: got %0b want 0", KICK); end
    pulse_rld(12'd5);
    n_cmp++; if (KICK !== 1'b1) begin n_bad++; $display("FAIL t1_kick_rise: got %0b want 1", KICK); end
    n_cmp++; if (POSY !== 12'd5 || POSX !== 12'd0) begin n_bad++; $display("FAIL t1_launch_pos: got posy=%0d posx=%0d want 5 0", POSY, POSX); end
    for (int i = 0; i < 1604; i++) begin
      IN_DE  = (i < 1600);
      OUT_DE = (i >= 2 && i < 1602);
      @(negedge CLK);
      if (i == 1598) begin
        n_cmp++; if (KICK !== 1'b1 || POSX !== 12'd1599) begin n_bad++; $display("FAIL t1_before_last: got kick=%0b posx=%0d want 1 1599", KICK, POSX); end
      end
      if (i == 1599) begin
        n_cmp++; if (KICK !== 1'b0 || POSX !== 12'd1600) begin n_bad++; $display("FAIL t1_kick_fall: got kick=%0b posx=%0d want 0 1600", KICK, POSX); end
      end
    end
    IN_DE = 1'b0; OUT_DE = 1'b0;
    n_cmp++; if (wld_cnt - base !== 1) begin n_bad++; $display("FAIL t1_wld_count: got %0d want 1", wld_cnt - base); end
    n_cmp++; if (last_wposy !== 12'd5) begin n_bad++; $display("FAIL t1_wposy: got %0d want 5", last_wposy); end
    n_cmp++; if (fd_cnt - fbase !== 0) begin n_bad++; $display("FAIL t1_no_frame_done: got %0d want 0", fd_cnt - fbase); end
    n_cmp++; if (BUSY !== 1'b0 || PROTO_ERR !== 1'b0) begin n_bad++; $display("FAIL t1_idle_clean: got busy=%0b perr=%0b want 0 0", BUSY, PROTO_ERR); end
  endtask

  task automatic test_frame_done;
    logic [PW-1:0] y_tab [2];
    int            fd_exp [2];
    int base, fbase;
    y_tab[0] = 12'd1; fd_exp[0] = 1;
    y_tab[1] = 12'd0; fd_exp[1] = 0;
    CFG_WIDTH = 12'd4; CFG_HEIGHT = 12'd2;
    for (int k = 0; k < 2; k++) begin
      base = wld_cnt; fbase = fd_cnt;
      pulse_rld(y_tab[k]);
      feed_in(4);
      feed_out(4);
      tick(2);
      n_cmp++; if (wld_cnt - base !== 1 || last_wposy !== y_tab[k]) begin n_bad++; $display("FAIL t2_wld_y%0d: got cnt=%0d wposy=%0d want 1 %0d", y_tab[k], wld_cnt - base, last_wposy, y_tab[k]); end
      n_cmp++; if (fd_cnt - fbase !== fd_exp[k]) begin n_bad++; $display("FAIL t2_frame_done_y%0d: got %0d want %0d", y_tab[k], fd_cnt - fbase, fd_exp[k]); end
    end
    n_cmp++; if (fd_orphan !== 0) begin n_bad++; $display("FAIL t2_fd_alone: got %0d want 0", fd_orphan); end
  endtask

  task automatic test_overrun;
    int base;
    CFG_WIDTH = 12'd4; CFG_HEIGHT = 12'd16;
    base = wld_cnt;
    pulse_rld(12'd3);
    IN_DE = 1'b1; @(negedge CLK);
    READ_POSY = 12'd7; READ_LINE_DONE = 1'b1; @(negedge CLK); READ_LINE_DONE = 1'b0;
    n_cmp++; if (LINE_READY !== 1'b0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL t3_pending: got ready=%0b busy=%0b want 0 1", LINE_READY, BUSY); end
    tick(2);
    IN_DE = 1'b0;
    n_cmp++; if (KICK !== 1'b0 || OVERRUN !== 1'b0) begin n_bad++; $display("FAIL t3_drain: got kick=%0b ovr=%0b want 0 0", KICK, OVERRUN); end
    READ_POSY = 12'd9; READ_LINE_DONE = 1'b1; OUT_DE = 1'b1; @(negedge CLK); READ_LINE_DONE = 1'b0;
    n_cmp++; if (OVERRUN !== 1'b1) begin n_bad++; $display("FAIL t3_overrun: got %0b want 1", OVERRUN); end
    tick(3);
    OUT_DE = 1'b0;
    n_cmp++; if (WRITE_LINE_DONE !== 1'b1 || WRITE_POSY !== 12'd3 || KICK !== 1'b0) begin n_bad++; $display("FAIL t3_first_done: got wld=%0b wposy=%0d kick=%0b want 1 3 0", WRITE_LINE_DONE, WRITE_POSY, KICK); end
    @(negedge CLK);
    n_cmp++; if (KICK !== 1'b1 || POSY !== 12'd7 || LINE_READY !== 1'b1) begin n_bad++; $display("FAIL t3_b2b_launch: got kick=%0b posy=%0d ready=%0b want 1 7 1", KICK, POSY, LINE_READY); end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
    n_cmp++; if (OVERRUN !== 1'b0) begin n_bad++; $display("FAIL t3_clr_err: got %0b want 0", OVERRUN); end
    feed_in(4);
    feed_out(4);
    tick(2);
    n_cmp++; if (wld_cnt - base !== 2 || last_wposy !== 12'd7) begin n_bad++; $display("FAIL t3_second_done: got cnt=%0d wposy=%0d want 2 7", wld_cnt - base, last_wposy); end
  endtask

  task automatic test_proto_err;
    int base;
    CFG_WIDTH = 12'd4; CFG_HEIGHT = 12'd16;
    base = wld_cnt;
    pulse_rld(12'd2);
    feed_in(4);
    n_cmp++; if (PROTO_ERR !== 1'b0 || POSX !== 12'd4) begin n_bad++; $display("FAIL t4_pre: got perr=%0b posx=%0d want 0 4", PROTO_ERR, POSX); end
    IN_DE = 1'b1; @(negedge CLK); IN_DE = 1'b0;
    n_cmp++; if (PROTO_ERR !== 1'b1 || POSX !== 12'd4) begin n_bad++; $display("FAIL t4_in_no_kick: got perr=%0b posx=%0d want 1 4", PROTO_ERR, POSX); end
    CLR_ERR = 1'b1; IN_DE = 1'b1; @(negedge CLK); CLR_ERR = 1'b0; IN_DE = 1'b0;
    n_cmp++; if (PROTO_ERR !== 1'b1) begin n_bad++; $display("FAIL t4_set_beats_clr: got %0b want 1", PROTO_ERR); end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
    n_cmp++; if (PROTO_ERR !== 1'b0) begin n_bad++; $display("FAIL t4_clr: got %0b want 0", PROTO_ERR); end
    feed_out(4);
    n_cmp++; if (WRITE_LINE_DONE !== 1'b1 || PROTO_ERR !== 1'b0) begin n_bad++; $display("FAIL t4_done: got wld=%0b perr=%0b want 1 0", WRITE_LINE_DONE, PROTO_ERR); end
    OUT_DE = 1'b1; @(negedge CLK); OUT_DE = 1'b0;
    n_cmp++; if (PROTO_ERR !== 1'b1 || WRITE_LINE_DONE !== 1'b0) begin n_bad++; $display("FAIL t4_extra_out: got perr=%0b wld=%0b want 1 0", PROTO_ERR, WRITE_LINE_DONE); end
    tick(2);
    n_cmp++; if (wld_cnt - base !== 1) begin n_bad++; $display("FAIL t4_wld_count: got %0d want 1", wld_cnt - base); end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
    CFG_WIDTH = 12'd0;
    pulse_rld(12'd4);
    n_cmp++; if (PROTO_ERR !== 1'b1 || KICK !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL t4_zero_width: got perr=%0b kick=%0b busy=%0b want 1 0 0", PROTO_ERR, KICK, BUSY); end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
  endtask

  task automatic test_reset_and_enable;
    int base;
    CFG_WIDTH = 12'd8; CFG_HEIGHT = 12'd16; ENABLE = 1'b1;
    base = wld_cnt;
    pulse_rld(12'd6);
    feed_in(3);
    n_cmp++; if (POSX !== 12'd3 || POSY !== 12'd6) begin n_bad++; $display("FAIL t5_mid_line: got posx=%0d posy=%0d want 3 6", POSX, POSY); end
    RST_N = 1'b0; @(negedge CLK); RST_N = 1'b1;
    n_cmp++; if ({KICK, POSX, POSY, WRITE_LINE_DONE, WRITE_POSY, FRAME_DONE, BUSY, OVERRUN, PROTO_ERR, TIMEOUT} !== '0) begin n_bad++; $display("FAIL t5_reset_abort: got kick=%0b posx=%0d posy=%0d wposy=%0d busy=%0b want all 0", KICK, POSX, POSY, WRITE_POSY, BUSY); end
    tick(12);
    n_cmp++; if (wld_cnt !== base || BUSY !== 1'b0) begin n_bad++; $display("FAIL t5_no_done: got cnt=%0d busy=%0b want %0d 0", wld_cnt, BUSY, base); end
    ENABLE = 1'b0;
    pulse_rld(12'd2);
    n_cmp++; if (BUSY !== 1'b1 || LINE_READY !== 1'b0 || KICK !== 1'b0) begin n_bad++; $display("FAIL t5_held: got busy=%0b ready=%0b kick=%0b want 1 0 0", BUSY, LINE_READY, KICK); end
    tick(3);
    n_cmp++; if (KICK !== 1'b0) begin n_bad++; $display("FAIL t5_no_launch: got %0b want 0", KICK); end
    ENABLE = 1'b1; #1;
    n_cmp++; if (LINE_READY !== 1'b0) begin n_bad++; $display("FAIL t5_ready_pend: got %0b want 0", LINE_READY); end
    @(negedge CLK);
    n_cmp++; if (KICK !== 1'b1 || POSY !== 12'd2 || LINE_READY !== 1'b1) begin n_bad++; $display("FAIL t5_launch: got kick=%0b posy=%0d ready=%0b want 1 2 1", KICK, POSY, LINE_READY); end
    feed_in(8);
    feed_out(8);
    tick(2);
    n_cmp++; if (wld_cnt - base !== 1 || last_wposy !== 12'd2) begin n_bad++; $display("FAIL t5_done: got cnt=%0d wposy=%0d want 1 2", wld_cnt - base, last_wposy); end
  endtask

  task automatic test_watchdog;
    int base;
    CFG_WIDTH = 12'd8; CFG_HEIGHT = 12'd16; ENABLE = 1'b1;
    base = wld_cnt;
    pulse_rld(12'd1);
    feed_in(2);
`ifdef LINE_SCHED_WDT_EN
    tick(15);
    n_cmp++; if (TIMEOUT !== 1'b0 || KICK !== 1'b1) begin n_bad++; $display("FAIL t6_before: got to=%0b kick=%0b want 0 1", TIMEOUT, KICK); end
    tick(1);
    n_cmp++; if (TIMEOUT !== 1'b1 || KICK !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL t6_timeout: got to=%0b kick=%0b busy=%0b want 1 0 0", TIMEOUT, KICK, BUSY); end
    tick(2);
    n_cmp++; if (wld_cnt !== base) begin n_bad++; $display("FAIL t6_no_done: got %0d want %0d", wld_cnt, base); end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
`else
    tick(40);
    n_cmp++; if (TIMEOUT !== 1'b0 || KICK !== 1'b1 || POSX !== 12'd2) begin n_bad++; $display("FAIL t6_no_wdt: got to=%0b kick=%0b posx=%0d want 0 1 2", TIMEOUT, KICK, POSX); end
    feed_in(6);
    feed_out(8);
    tick(2);
    n_cmp++; if (wld_cnt - base !== 1 || last_wposy !== 12'd1) begin n_bad++; $display("FAIL t6_done: got cnt=%0d wposy=%0d want 1 1", wld_cnt - base, last_wposy); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_frame_done();
    test_overrun();
    test_proto_err();
    test_reset_and_enable();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
